spi_sample_streamer: RTL and testbench

- Sample-buffering front end for the SPI peripheral in the ADC/DSP design.
- Queues ADC samples in a small FIFO.
- Drives the peripheral's D_TO_SEND byte by byte with a fixed frame layout: status, sample high byte, sample low byte.
- Decodes the host command byte from RX_DATA/RX_DONE to pop or flush the FIFO at end of frame.

---
 rtl/spi_sample_streamer.sv | 206 ++++++++++++++++++++
 tb/tb_spi_sample_streamer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sample_streamer.sv
// -----------------------------------------------------------------------------
// spi_sample_streamer
//
// Sample-buffering front end for the SPI peripheral. ADC samples are queued in
// a small circular FIFO. Each SPI frame returns three bytes on MISO:
//   status {OVERFLOW, min(FIFO_COUNT,127)}, sample high byte, sample low byte.
// The first MOSI byte of a frame is a command that runs when chip select rises,
// and only if the frame carried at least three bytes:
//   0xA5 pops the sample that was sent, 0x5A flushes the FIFO, others are ignored.
//
// Ports
//   sys_clk       system clock, shared with the SPI peripheral
//   sys_rst_n     synchronous active-low reset
//   SAMPLE_IN     ADC sample, zero-extended to 16 bits for transmission
//   SAMPLE_VALID  one-cycle push strobe for SAMPLE_IN
//   CSN_PAD       raw chip select, the same net the peripheral samples
//   RX_DONE       one-cycle byte-complete strobe from the peripheral
//   RX_DATA       received MOSI byte, valid while RX_DONE=1
//   D_TO_SEND     registered byte the peripheral will shift out next
//   FIFO_COUNT    current fill level, 0..2**DEPTH_LOG2
//   OVERFLOW      sticky: a push was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module spi_sample_streamer #(
  parameter int SAMPLE_W   = 12,
  parameter int DEPTH_LOG2 = 4,
  parameter int BYTE_W     = 8
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [SAMPLE_W-1:0] SAMPLE_IN,
  input  logic                SAMPLE_VALID,
  input  logic                CSN_PAD,
  input  logic                RX_DONE,
  input  logic [BYTE_W-1:0]   RX_DATA,
  output logic [BYTE_W-1:0]   D_TO_SEND,
  output logic [DEPTH_LOG2:0] FIFO_COUNT,
  output logic                OVERFLOW
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [2:0] ST_RESYNC = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_BYTE0  = 3'd2;
  localparam logic [2:0] ST_BYTE1  = 3'd3;
  localparam logic [2:0] ST_BYTE2  = 3'd4;
  localparam logic [2:0] ST_TAIL   = 3'd5;

  localparam logic [BYTE_W-1:0] CMD_POP   = 8'hA5;
  localparam logic [BYTE_W-1:0] CMD_FLUSH = 8'h5A;

  // Status byte: sticky overflow flag over the fill level clamped to 7 bits.
  function automatic logic [7:0] status_byte(input logic ovf,
                                             input logic [DEPTH_LOG2:0] cnt);
    logic [7:0] c8;
    logic [7:0] res;
    c8 = 8'(cnt);
    if (c8 > 8'd127) res = {ovf, 7'd127};
    else             res = {ovf, c8[6:0]};
    return res;
  endfunction

  // FIFO storage and control
  logic [SAMPLE_W-1:0]   r_mem [0:DEPTH-1];
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;

  // Frame control
  logic [2:0]            r_state;
  logic [BYTE_W-1:0]     r_d_to_send;
  logic [BYTE_W-1:0]     r_cmd;
  logic [1:0]            r_byte_cnt;
  logic [15:0]           r_snap;
  logic                  r_snap_valid;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_in_frame;
  logic                  w_frame_end;
  logic                  w_complete;
  logic                  w_flush;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [15:0]           w_head;
  logic [7:0]            w_status;

  // The count never exceeds DEPTH, so its MSB alone marks the full state.
  assign w_full   = r_count[DEPTH_LOG2];
  assign w_empty  = (r_count == '0);
  assign w_head   = w_empty ? 16'h0000 : 16'(r_mem[r_rd_ptr]);
  assign w_status = status_byte(r_overflow, r_count);

  assign w_in_frame  = (r_state != ST_RESYNC) && (r_state != ST_IDLE);
  assign w_frame_end = w_in_frame && CSN_PAD;
  // The byte counter saturates at 3; reaching it means a full frame arrived.
  assign w_complete  = (r_byte_cnt == 2'd3);

  assign w_flush = w_frame_end && w_complete && (r_cmd == CMD_FLUSH);
  // The snapped sample is still the oldest entry, so popping the head removes
  // exactly the sample that went out on MISO.
  assign w_pop   = w_frame_end && w_complete && (r_cmd == CMD_POP) &&
                   r_snap_valid && !w_empty;
  // A push that coincides with a flush is discarded rather than kept.
  assign w_push  = sys_rst_n && SAMPLE_VALID && !w_full && !w_flush;
  assign w_drop  = SAMPLE_VALID && w_full && !w_flush;

  // FIFO pointers, fill level and overflow flag
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_flush) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Sample storage (data path, no reset)
  always_ff @(posedge sys_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= SAMPLE_IN;
  end

  // Head snapshot taken at frame start; later pushes cannot disturb it.
  always_ff @(posedge sys_clk) begin
    if ((r_state == ST_IDLE) && !CSN_PAD) r_snap <= w_head;
  end

  // Frame FSM. D_TO_SEND always holds the byte for the next transfer: the
  // peripheral samples it on the CSN fall cycle and on every RX_DONE cycle,
  // and we replace it on the edge right after.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state      <= ST_RESYNC;
      r_d_to_send  <= '0;
      r_cmd        <= '0;
      r_byte_cnt   <= 2'd0;
      r_snap_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_RESYNC: begin
          // Wait out any frame already in progress before trusting byte timing.
          r_d_to_send <= w_status;
          if (CSN_PAD) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (!CSN_PAD) begin
            r_snap_valid <= !w_empty;
            r_d_to_send  <= w_head[15:8];
            r_byte_cnt   <= 2'd0;
            r_state      <= ST_BYTE0;
          end else begin
            r_d_to_send  <= w_status;
          end
        end
        default: begin
          if (CSN_PAD) begin
            r_d_to_send <= w_status;
            r_state     <= ST_IDLE;
          end else if (RX_DONE) begin
            if (r_byte_cnt != 2'd3) r_byte_cnt <= r_byte_cnt + 2'd1;
            case (r_state)
              ST_BYTE0: begin
                r_cmd       <= RX_DATA;
                r_d_to_send <= r_snap[7:0];
                r_state     <= ST_BYTE1;
              end
              ST_BYTE1: begin
                r_d_to_send <= '0;
                r_state     <= ST_BYTE2;
              end
              ST_BYTE2: begin
                r_d_to_send <= '0;
                r_state     <= ST_TAIL;
              end
              default: begin
                r_d_to_send <= '0;
                r_state     <= ST_TAIL;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign D_TO_SEND  = r_d_to_send;
  assign FIFO_COUNT = r_count;
  assign OVERFLOW   = r_overflow;

endmodule

// File: tb/tb_spi_sample_streamer.sv
// -----------------------------------------------------------------------------
// Bench for spi_sample_streamer: directed frame table, a pointer-wrap loop,
// reset-in-mid-frame sequences and randomized frames checked against a
// queue-based reference model of the FIFO and frame protocol.
// -----------------------------------------------------------------------------
module tb_spi_sample_streamer;

  localparam int SAMPLE_W   = 12;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [SAMPLE_W-1:0] sin;
  logic                sv;
  logic                csn;
  logic                rxd;
  logic [7:0]          rxdata;
  logic [7:0]          d_to_send;
  logic [DEPTH_LOG2:0] fifo_count;
  logic                overflow;

  spi_sample_streamer #(
    .SAMPLE_W   (SAMPLE_W),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .BYTE_W     (8)
  ) dut (
    .sys_clk      (clk),
    .sys_rst_n    (rst_n),
    .SAMPLE_IN    (sin),
    .SAMPLE_VALID (sv),
    .CSN_PAD      (csn),
    .RX_DONE      (rxd),
    .RX_DATA      (rxdata),
    .D_TO_SEND    (d_to_send),
    .FIFO_COUNT   (fifo_count),
    .OVERFLOW     (overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  logic [15:0] m_q[$];
  bit          m_ovf;
  bit          m_in_frame;
  bit          m_resync;
  int          m_nbytes;
  logic [7:0]  m_cmd;
  logic [15:0] m_snap;
  bit          m_snap_valid;
  logic [7:0]  got [0:7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] mstat();
    int c;
    c = m_q.size();
    if (c > 127) c = 127;
    return {m_ovf, c[6:0]};
  endfunction

  function automatic logic [7:0] exp_byte(input int idx);
    if (idx == 1) return m_snap[15:8];
    if (idx == 2) return m_snap[7:0];
    return 8'h00;
  endfunction

  // One clock cycle: inputs are already driven; the peripheral's view of
  // D_TO_SEND is checked before the edge, count/overflow after it.
  task automatic cyc();
    bit pop, flush, push, drop;
    logic [15:0] s;
    pop = 0; flush = 0; push = 0; drop = 0;
    s = 16'(sin);
    if (!rst_n) begin
      m_q.delete();
      m_ovf = 0; m_in_frame = 0; m_resync = 1; m_nbytes = 0; m_cmd = 8'h00;
    end else begin
      if (!m_in_frame && !m_resync && !csn) begin
        got[0] = d_to_send;
        chk("miso_status", 32'(d_to_send), 32'(mstat()));
        m_snap_valid = (m_q.size() > 0);
        m_snap       = m_snap_valid ? m_q[0] : 16'h0000;
        m_in_frame   = 1;
        m_nbytes     = 0;
      end else if (m_in_frame && !csn && rxd) begin
        if (m_nbytes < 7) got[m_nbytes+1] = d_to_send;
        chk("miso_byte", 32'(d_to_send), 32'(exp_byte(m_nbytes + 1)));
        if (m_nbytes == 0) m_cmd = rxdata;
        m_nbytes++;
      end
      if (m_in_frame && csn) begin
        if (m_nbytes >= 3 && m_cmd == 8'h5A) flush = 1;
        if (m_nbytes >= 3 && m_cmd == 8'hA5 && m_snap_valid) pop = 1;
        m_in_frame = 0;
      end
      if (m_resync && csn) m_resync = 0;
      if (sv && !flush) begin
        if (m_q.size() < DEPTH) push = 1;
        else                    drop = 1;
      end
    end
    @(posedge clk);
    if (flush) begin m_q.delete(); m_ovf = 0; end
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back(s);
    if (drop) m_ovf = 1;
    @(negedge clk);
    chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic push(input logic [15:0] v);
    sv = 1'b1; sin = v[SAMPLE_W-1:0];
    cyc();
    sv = 1'b0;
  endtask

  task automatic rnd_sv(input bit rnd);
    if (rnd) begin
      sv  = ($urandom_range(0, 2) == 0);
      sin = SAMPLE_W'($urandom);
    end else begin
      sv = 1'b0;
    end
  endtask

  // Full SPI frame as the peripheral would present it. Two quiet idle cycles
  // precede the CSN fall so the status byte reflects a settled count.
  task automatic frame(input logic [7:0] cmd, input int nb, input bit rnd,
                       input bit end_push, input logic [15:0] end_s);
    for (int i = 0; i < 8; i++) got[i] = 'x;
    sv = 1'b0; rxd = 1'b0; csn = 1'b1;
    repeat (2) cyc();
    csn = 1'b0; rnd_sv(rnd);
    cyc();
    for (int b = 0; b < nb; b++) begin
      repeat ($urandom_range(1, 3)) begin rnd_sv(rnd); cyc(); end
      rnd_sv(rnd);
      rxd = 1'b1; rxdata = (b == 0) ? cmd : 8'h00;
      cyc();
      rxd = 1'b0;
    end
    rnd_sv(rnd); cyc();
    csn = 1'b1; sv = end_push; sin = end_s[SAMPLE_W-1:0];
    cyc();
    sv = 1'b0;
    cyc();
  endtask

  // Reset while the frame sits in BYTE1 with CSN still low.
  task automatic reset_mid(input bit push_rs);
    csn = 1'b1; sv = 1'b0; rxd = 1'b0;
    repeat (2) cyc();
    csn = 1'b0; cyc();
    repeat (2) cyc();
    rxd = 1'b1; rxdata = 8'hA5; cyc(); rxd = 1'b0;
    cyc();
    rst_n = 1'b0; cyc(); cyc();
    chk("rstmid_dts", 32'(d_to_send), 32'h00);
    chk("rstmid_cnt", 32'(fifo_count), 32'h0);
    rst_n = 1'b1;
    if (push_rs) push(16'h0666);
    for (int b = 0; b < 3; b++) begin
      cyc();
      rxd = 1'b1; rxdata = (b == 0) ? 8'hA5 : 8'h00;
      cyc();
      rxd = 1'b0;
    end
    csn = 1'b1; cyc(); cyc();
    chk("rstmid_nocmd", 32'(fifo_count), push_rs ? 32'h1 : 32'h0);
    frame(8'h00, 3, 0, 0, 16'h0);
    chk("rstmid_status", 32'(got[0]), push_rs ? 32'h01 : 32'h00);
  endtask

  typedef struct {
    int          npush;
    logic [15:0] first;
    logic [15:0] step;
    int          pre_cnt;
    bit          pre_ovf;
    logic [7:0]  cmd;
    int          nb;
    bit          end_push;
    logic [15:0] end_s;
    logic [7:0]  e0, e1, e2;
    int          post_cnt;
    bit          post_ovf;
  } vec_t;

  vec_t        tbl [9];
  logic [15:0] v;
  logic [7:0]  c;
  int          r;

  initial begin
    tbl[0] = '{1,  16'h0ABC, 16'h0000, 1,  0, 8'hA5, 3, 0, 16'h0000, 8'h01, 8'h0A, 8'hBC, 0, 0};
    tbl[1] = '{0,  16'h0000, 16'h0000, 0,  0, 8'hA5, 3, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 0, 0};
    tbl[2] = '{17, 16'h0001, 16'h0001, 16, 1, 8'h5A, 3, 0, 16'h0000, 8'h90, 8'h00, 8'h01, 0, 0};
    tbl[3] = '{0,  16'h0000, 16'h0000, 0,  0, 8'h00, 3, 0, 16'h0000, 8'h00, 8'h00, 8'h00, 0, 0};
    tbl[4] = '{2,  16'h0111, 16'h0111, 2,  0, 8'hA5, 3, 1, 16'h0333, 8'h02, 8'h01, 8'h11, 2, 0};
    tbl[5] = '{0,  16'h0000, 16'h0000, 2,  0, 8'hA5, 3, 0, 16'h0000, 8'h02, 8'h02, 8'h22, 1, 0};
    tbl[6] = '{0,  16'h0000, 16'h0000, 1,  0, 8'hA5, 3, 0, 16'h0000, 8'h01, 8'h03, 8'h33, 0, 0};
    tbl[7] = '{1,  16'h0444, 16'h0000, 1,  0, 8'hA5, 2, 0, 16'h0000, 8'h01, 8'h04, 8'h44, 1, 0};
    tbl[8] = '{0,  16'h0000, 16'h0000, 1,  0, 8'hA5, 5, 0, 16'h0000, 8'h01, 8'h04, 8'h44, 0, 0};

    rst_n = 1'b0; csn = 1'b1; sv = 1'b0; rxd = 1'b0; sin = '0; rxdata = 8'h00;
    m_resync = 1;
    @(negedge clk);
    repeat (3) cyc();
    chk("reset_dts", 32'(d_to_send), 32'h00);
    chk("reset_cnt", 32'(fifo_count), 32'h0);
    chk("reset_ovf", 32'(overflow), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < tbl[i].npush; k++) push(tbl[i].first + 16'(k) * tbl[i].step);
      chk("tbl_pre_cnt", 32'(fifo_count), 32'(tbl[i].pre_cnt));
      chk("tbl_pre_ovf", 32'(overflow), 32'(tbl[i].pre_ovf));
      frame(tbl[i].cmd, tbl[i].nb, 0, tbl[i].end_push, tbl[i].end_s);
      chk("tbl_miso0", 32'(got[0]), 32'(tbl[i].e0));
      chk("tbl_miso1", 32'(got[1]), 32'(tbl[i].e1));
      chk("tbl_miso2", 32'(got[2]), 32'(tbl[i].e2));
      chk("tbl_post_cnt", 32'(fifo_count), 32'(tbl[i].post_cnt));
      chk("tbl_post_ovf", 32'(overflow), 32'(tbl[i].post_ovf));
    end

    for (int i = 0; i < 20; i++) begin
      v = 16'((i * 37 + 5) & 12'hFFF);
      push(v);
      frame(8'hA5, 3, 0, 0, 16'h0);
      chk("wrap_hi", 32'(got[1]), 32'(v[15:8]));
      chk("wrap_lo", 32'(got[2]), 32'(v[7:0]));
    end
    chk("wrap_cnt", 32'(fifo_count), 32'h0);

    reset_mid(0);
    reset_mid(1);

    for (int f = 0; f < 60; f++) begin
      repeat ($urandom_range(0, 4)) begin
        rnd_sv(1);
        rxd = ($urandom_range(0, 5) == 0);
        rxdata = 8'($urandom);
        cyc();
      end
      rxd = 1'b0;
      r = $urandom_range(0, 3);
      if (r < 2)       c = 8'hA5;
      else if (r == 2) c = 8'h5A;
      else             c = 8'($urandom);
      frame(c, $urandom_range(1, 5), 1, 1'($urandom_range(0, 1)), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
